// File: rtl/alu_seq_pkg.sv
// rtl/alu_seq_pkg.sv - opcodes, state encoding and ALU strobe indices for alu_control_sequencer
package alu_seq_pkg;

    localparam logic [4:0] OP_ADD  = 5'b00011;
    localparam logic [4:0] OP_SUB  = 5'b00100;
    localparam logic [4:0] OP_AND  = 5'b00101;
    localparam logic [4:0] OP_OR   = 5'b00110;
    localparam logic [4:0] OP_ROR  = 5'b00111;
    localparam logic [4:0] OP_ROL  = 5'b01000;
    localparam logic [4:0] OP_SHR  = 5'b01001;
    localparam logic [4:0] OP_SHRA = 5'b01010;
    localparam logic [4:0] OP_SHL  = 5'b01011;
    localparam logic [4:0] OP_MUL  = 5'b01111;
    localparam logic [4:0] OP_DIV  = 5'b10000;
    localparam logic [4:0] OP_NEG  = 5'b10001;
    localparam logic [4:0] OP_NOT  = 5'b10010;
    localparam logic [4:0] OP_HALT = 5'b11011;

    localparam int ALU_AND  = 0;
    localparam int ALU_OR   = 1;
    localparam int ALU_ADD  = 2;
    localparam int ALU_SUB  = 3;
    localparam int ALU_MUL  = 4;
    localparam int ALU_DIV  = 5;
    localparam int ALU_SHR  = 6;
    localparam int ALU_SHRA = 7;
    localparam int ALU_SHL  = 8;
    localparam int ALU_ROR  = 9;
    localparam int ALU_ROL  = 10;
    localparam int ALU_NEG  = 11;
    localparam int ALU_NOT  = 12;

    typedef enum logic [3:0] {
        S_IDLE = 4'd0,
        S_T0   = 4'd1,
        S_T1   = 4'd2,
        S_T2   = 4'd3,
        S_T3   = 4'd4,
        S_T4   = 4'd5,
        S_T5   = 4'd6,
        S_T6   = 4'd7,
        S_HALT = 4'd8
    } state_t;

    typedef enum logic [2:0] {
        CLS_3REG,
        CLS_MULDIV,
        CLS_UNARY,
        CLS_HALT,
        CLS_ILLEGAL
    } op_class_t;

    function automatic op_class_t op_class(input logic [4:0] op);
        op_class_t c;
        c = CLS_ILLEGAL;
        case (op)
            OP_ADD, OP_SUB, OP_AND, OP_OR, OP_ROR,
            OP_ROL, OP_SHR, OP_SHRA, OP_SHL: c = CLS_3REG;
            OP_MUL, OP_DIV:                  c = CLS_MULDIV;
            OP_NEG, OP_NOT:                  c = CLS_UNARY;
            OP_HALT:                         c = CLS_HALT;
            default:                         c = CLS_ILLEGAL;
        endcase
        return c;
    endfunction

    function automatic logic [3:0] alu_index(input logic [4:0] op);
        logic [3:0] idx;
        idx = 4'(ALU_AND);
        case (op)
            OP_ADD:  idx = 4'(ALU_ADD);
            OP_SUB:  idx = 4'(ALU_SUB);
            OP_AND:  idx = 4'(ALU_AND);
            OP_OR:   idx = 4'(ALU_OR);
            OP_ROR:  idx = 4'(ALU_ROR);
            OP_ROL:  idx = 4'(ALU_ROL);
            OP_SHR:  idx = 4'(ALU_SHR);
            OP_SHRA: idx = 4'(ALU_SHRA);
            OP_SHL:  idx = 4'(ALU_SHL);
            OP_MUL:  idx = 4'(ALU_MUL);
            OP_DIV:  idx = 4'(ALU_DIV);
            OP_NEG:  idx = 4'(ALU_NEG);
            OP_NOT:  idx = 4'(ALU_NOT);
            default: idx = 4'(ALU_AND);
        endcase
        return idx;
    endfunction

endpackage

// File: rtl/reg_onehot_decoder.sv
// rtl/reg_onehot_decoder.sv - 4-bit register index plus enable to one-hot register strobe vector
module reg_onehot_decoder #(
    parameter int NUM_REGS = 16
) (
    input  logic [3:0]          i_idx,
    input  logic                i_en,
    output logic [NUM_REGS-1:0] o_onehot
);

    // Indices beyond NUM_REGS shift out and yield no strobe at all.
    assign o_onehot = i_en ? (NUM_REGS'(1) << i_idx) : '0;

endmodule

// File: rtl/alu_control_sequencer.sv
// rtl/alu_control_sequencer.sv - Moore fetch/execute control sequencer for register ALU instructions
// Optional single-step input enabled by defining ALU_SEQ_SINGLE_STEP_EN.
module alu_control_sequencer #(
    parameter int NUM_REGS = 16,
    parameter int ALU_OPS  = 13
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
`ifdef ALU_SEQ_SINGLE_STEP_EN
    input  logic                step,
`endif
    input  logic [31:0]         IR,
    output logic                run,
    output logic                done,
    output logic                err,
    output logic                PCout,
    output logic                MARin,
    output logic                IncPC,
    output logic                PCin,
    output logic                Read,
    output logic                MDRin,
    output logic                MDRout,
    output logic                IRin,
    output logic                Yin,
    output logic                Zin,
    output logic                Zhighout,
    output logic                Zlowout,
    output logic                HIin,
    output logic                LOin,
    output logic [NUM_REGS-1:0] Rin,
    output logic [NUM_REGS-1:0] Rout,
    output logic [ALU_OPS-1:0]  alu_op
);
    import alu_seq_pkg::*;

    state_t     r_state;
    state_t     w_state_next;
    logic       r_err;
    logic       w_adv;
    logic [4:0] w_opcode;
    logic [3:0] w_ra, w_rb, w_rc;
    op_class_t  w_class;
    logic       w_rin_en, w_rout_en, w_alu_en;
    logic [3:0] w_rout_idx;
    logic       w_unused_ir;

    assign w_opcode    = IR[31:27];
    assign w_ra        = IR[26:23];
    assign w_rb        = IR[22:19];
    assign w_rc        = IR[18:15];
    assign w_unused_ir = &{1'b0, IR[14:0]};
    assign w_class     = op_class(w_opcode);

`ifdef ALU_SEQ_SINGLE_STEP_EN
    assign w_adv = step;
`else
    assign w_adv = 1'b1;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_state_next;
            if (w_adv && r_state == S_T3 && w_class == CLS_ILLEGAL)
                r_err <= 1'b1;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE: if (start) w_state_next = S_T0;
            S_T0:   w_state_next = S_T1;
            S_T1:   w_state_next = S_T2;
            S_T2:   w_state_next = S_T3;
            S_T3:   w_state_next = (w_class == CLS_HALT || w_class == CLS_ILLEGAL) ? S_HALT : S_T4;
            S_T4:   w_state_next = (w_class == CLS_UNARY) ? S_T0 : S_T5;
            S_T5:   w_state_next = (w_class == CLS_MULDIV) ? S_T6 : S_T0;
            S_T6:   w_state_next = S_T0;
            S_HALT: w_state_next = S_HALT;
            default: w_state_next = S_IDLE;
        endcase
        if (!w_adv)
            w_state_next = r_state;
    end

    always_comb begin
        {PCout, MARin, IncPC, PCin, Read, MDRin, MDRout, IRin} = '0;
        {Yin, Zin, Zhighout, Zlowout, HIin, LOin, done}        = '0;
        w_rin_en   = 1'b0;
        w_rout_en  = 1'b0;
        w_alu_en   = 1'b0;
        w_rout_idx = w_rb;
        case (r_state)
            S_T0: {PCout, MARin, IncPC, PCin} = 4'hF;
            S_T1: {Read, MDRin} = 2'b11;
            S_T2: {MDRout, IRin} = 2'b11;
            S_T3: begin
                // MUL/DIV put ra in Y first; unary ops go straight to the ALU with rb.
                case (w_class)
                    CLS_3REG:   begin w_rout_en = 1'b1; Yin = 1'b1; end
                    CLS_MULDIV: begin w_rout_en = 1'b1; w_rout_idx = w_ra; Yin = 1'b1; end
                    CLS_UNARY:  begin w_rout_en = 1'b1; w_alu_en = 1'b1; Zin = 1'b1; end
                    default: ;
                endcase
            end
            S_T4: begin
                case (w_class)
                    CLS_3REG:   begin w_rout_en = 1'b1; w_rout_idx = w_rc; w_alu_en = 1'b1; Zin = 1'b1; end
                    CLS_MULDIV: begin w_rout_en = 1'b1; w_alu_en = 1'b1; Zin = 1'b1; end
                    CLS_UNARY:  begin Zlowout = 1'b1; w_rin_en = 1'b1; done = 1'b1; end
                    default: ;
                endcase
            end
            S_T5: begin
                case (w_class)
                    CLS_3REG:   begin Zlowout = 1'b1; w_rin_en = 1'b1; done = 1'b1; end
                    CLS_MULDIV: begin Zlowout = 1'b1; LOin = 1'b1; end
                    default: ;
                endcase
            end
            S_T6: begin Zhighout = 1'b1; HIin = 1'b1; done = 1'b1; end
            default: ;
        endcase
    end

    assign run    = (r_state != S_IDLE) && (r_state != S_HALT);
    assign err    = r_err;
    assign alu_op = w_alu_en ? (ALU_OPS'(1) << alu_index(w_opcode)) : '0;

    reg_onehot_decoder #(.NUM_REGS(NUM_REGS)) u_rin_dec (
        .i_idx    (w_ra),
        .i_en     (w_rin_en),
        .o_onehot (Rin)
    );

    reg_onehot_decoder #(.NUM_REGS(NUM_REGS)) u_rout_dec (
        .i_idx    (w_rout_idx),
        .i_en     (w_rout_en),
        .o_onehot (Rout)
    );

endmodule
